// File: rtl/threshold_integrator_ctrl.sv
// Sequencer for one threshold_integrator: shadows its configuration, walks it through
// reset/enable/setup, and latches the first fault with a code until software clears it.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | integrator held in reset, configuration accepted, waiting for arm
// CLEAR   | integrator reset held low for RESET_CYCLES before enabling
// ARM     | integrator enabled, waiting for int_setup_done with a timeout
// RUNNING | integrator operating, flags monitored
// FAULT   | fault latched, integrator disabled but not reset (state kept for diagnosis)
module threshold_integrator_ctrl #(
    parameter int RESET_CYCLES  = 4,
    parameter int SETUP_TIMEOUT = 1048576,
    parameter int MIN_WINDOW    = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_window,
    input  logic [14:0] cfg_threshold,
    input  logic        arm,
    input  logic        disarm,
    input  logic        fault_clear,
    output logic        int_resetn,
    output logic        int_enable,
    output logic [31:0] int_window,
    output logic [14:0] int_threshold_average,
    input  logic        int_setup_done,
    input  logic        int_over_thresh,
    input  logic        int_err_overflow,
    input  logic        int_err_underflow,
    output logic        running,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        fault_irq
);

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int TW = $clog2(SETUP_TIMEOUT) + 1;
    localparam logic [RW-1:0] RLOAD = RW'(RESET_CYCLES);
    localparam logic [TW-1:0] TMAX  = TW'(SETUP_TIMEOUT - 1);
    localparam logic [31:0]   MIN_W = 32'(MIN_WINDOW);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_OVER     = 3'd1;
    localparam logic [2:0] CODE_OVERFLOW = 3'd2;
    localparam logic [2:0] CODE_UNDER    = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT  = 3'd4;
    localparam logic [2:0] CODE_BAD_WIN  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_RUNNING, S_FAULT
    } state_t;

    state_t        state, state_next;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tcnt;
    logic [2:0]    code_next;
    logic          cfg_xfer;
    logic [31:0]   eff_window;
    logic          flag_any;
    logic [2:0]    flag_code;

    logic int_resetn_d, int_enable_d, running_d, fault_d, fault_irq_d;

    assign cfg_ready  = (state == S_IDLE);
    assign cfg_xfer   = cfg_valid & cfg_ready;
    assign eff_window = cfg_xfer ? cfg_window : int_window;
    assign flag_any   = int_err_overflow | int_err_underflow | int_over_thresh;

    always_comb begin
        flag_code = CODE_OVER;
        if (int_err_overflow)       flag_code = CODE_OVERFLOW;
        else if (int_err_underflow) flag_code = CODE_UNDER;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Flags take precedence over disarm so a fault coinciding with a stop is never lost.
    always_comb begin
        state_next = state;
        code_next  = CODE_NONE;
        case (state)
            S_IDLE: begin
                if (arm && !disarm) begin
                    if (eff_window < MIN_W) begin
                        state_next = S_FAULT;
                        code_next  = CODE_BAD_WIN;
                    end else begin
                        state_next = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (disarm)         state_next = S_IDLE;
                else if (rcnt == '0) state_next = S_ARM;
            end
            S_ARM: begin
                if (flag_any) begin
                    state_next = S_FAULT;
                    code_next  = flag_code;
                end else if (disarm) begin
                    state_next = S_IDLE;
                end else if (int_setup_done) begin
                    state_next = S_RUNNING;
                end else if (tcnt == TMAX) begin
                    state_next = S_FAULT;
                    code_next  = CODE_TIMEOUT;
                end
            end
            S_RUNNING: begin
                if (flag_any) begin
                    state_next = S_FAULT;
                    code_next  = flag_code;
                end else if (disarm) begin
                    state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                if (fault_clear) state_next = S_IDLE;
                else             code_next  = fault_code;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        int_resetn_d = (state_next == S_ARM) || (state_next == S_RUNNING) || (state_next == S_FAULT);
        int_enable_d = (state_next == S_ARM) || (state_next == S_RUNNING);
        running_d    = (state_next == S_RUNNING);
        fault_d      = (state_next == S_FAULT);
        fault_irq_d  = (state_next == S_FAULT) && (state != S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_resetn            <= 1'b0;
            int_enable            <= 1'b0;
            running               <= 1'b0;
            fault                 <= 1'b0;
            fault_irq             <= 1'b0;
            fault_code            <= CODE_NONE;
            int_window            <= '0;
            int_threshold_average <= '0;
            rcnt                  <= '0;
            tcnt                  <= '0;
        end else begin
            int_resetn <= int_resetn_d;
            int_enable <= int_enable_d;
            running    <= running_d;
            fault      <= fault_d;
            fault_irq  <= fault_irq_d;
            fault_code <= code_next;
            if (cfg_xfer) begin
                int_window            <= cfg_window;
                int_threshold_average <= cfg_threshold;
            end
            if (state_next == S_CLEAR && state != S_CLEAR)
                rcnt <= RLOAD;
            else if (state == S_CLEAR && rcnt != '0)
                rcnt <= rcnt - 1'b1;
            // Timeout counter saturates rather than wrapping.
            if (state_next == S_ARM && state != S_ARM)
                tcnt <= '0;
            else if (state == S_ARM && tcnt != '1)
                tcnt <= tcnt + 1'b1;
        end
    end

endmodule
